// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset datapath: FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshakes, a retired-instruction counter and a sticky illegal-opcode flag.
module multicycle_ctrl #(
  parameter bit          ILLEGAL_TRAP = 1'b1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Zero,
  input  logic             IMemReady,
  input  logic             DMemReady,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultToReg,
  output logic [1:0]       WriteRegDst,
  output logic [2:0]       ALUOp,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [1:0]       ExtOp,
  output logic [2:0]       State,
  output logic             InstrDone,
  output logic             IllegalInstr,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100,
    StHalt   = 3'b101
  } state_e;

  typedef enum logic [3:0] {
    ClsIllegal, ClsAluR, ClsAluI, ClsLoad, ClsStore, ClsBranch, ClsJump, ClsJal, ClsJr
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls;
  logic [2:0]       alu_op_dec;
  logic             alu_src_a_dec, alu_src_b_dec, is_bne;
  logic [1:0]       ext_op_dec;
  logic             ir_write_c, pc_write_c, mem_write_c, reg_write_c, done_c;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  // Instruction class and the EXEC-time ALU controls for the current Op/Func.
  always_comb begin
    cls           = ClsIllegal;
    alu_op_dec    = 3'b000;
    alu_src_a_dec = 1'b0;
    alu_src_b_dec = 1'b0;
    ext_op_dec    = 2'b00;
    is_bne        = 1'b0;
    case (Op)
      6'b000000: begin
        case (Func)
          6'b100000, 6'b100001: cls = ClsAluR;
          6'b100010, 6'b100011: begin cls = ClsAluR; alu_op_dec = 3'b001; end
          6'b100100: begin cls = ClsAluR; alu_op_dec = 3'b011; end
          6'b100101: begin cls = ClsAluR; alu_op_dec = 3'b010; end
          6'b100110: begin cls = ClsAluR; alu_op_dec = 3'b100; end
          6'b000000: begin
            cls = ClsAluR; alu_op_dec = 3'b101; alu_src_a_dec = 1'b1; ext_op_dec = 2'b11;
          end
          6'b000010: begin
            cls = ClsAluR; alu_op_dec = 3'b110; alu_src_a_dec = 1'b1; ext_op_dec = 2'b11;
          end
          6'b001000: cls = ClsJr;
          default:   cls = ClsIllegal;
        endcase
      end
      6'b001000, 6'b001001: begin cls = ClsAluI; alu_src_b_dec = 1'b1; end
      6'b001101: begin
        cls = ClsAluI; alu_op_dec = 3'b010; alu_src_b_dec = 1'b1; ext_op_dec = 2'b01;
      end
      6'b001111: begin cls = ClsAluI; alu_src_b_dec = 1'b1; ext_op_dec = 2'b10; end
      6'b100011: begin cls = ClsLoad;  alu_src_b_dec = 1'b1; end
      6'b101011: begin cls = ClsStore; alu_src_b_dec = 1'b1; end
      6'b000100: begin cls = ClsBranch; alu_op_dec = 3'b001; end
      6'b000101: begin cls = ClsBranch; alu_op_dec = 3'b001; is_bne = 1'b1; end
      6'b000010: cls = ClsJump;
      6'b000011: cls = ClsJal;
      default:   cls = ClsIllegal;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    done_c      = 1'b0;
    PCSrc       = 2'b00;
    ResultToReg = 2'b00;
    WriteRegDst = 2'b00;
    ALUOp       = 3'b000;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 1'b0;
    ExtOp       = 2'b00;
    case (state_q)
      StFetch: begin
        if (IMemReady) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        case (cls)
          ClsJump: begin
            pc_write_c = 1'b1; PCSrc = 2'b10; done_c = 1'b1; state_d = StFetch;
          end
          ClsJal: begin
            pc_write_c  = 1'b1; PCSrc = 2'b10; reg_write_c = 1'b1;
            WriteRegDst = 2'b10; ResultToReg = 2'b10; done_c = 1'b1; state_d = StFetch;
          end
          ClsJr: begin
            pc_write_c = 1'b1; PCSrc = 2'b11; done_c = 1'b1; state_d = StFetch;
          end
          ClsIllegal: begin
            if (ILLEGAL_TRAP) begin
              state_d = StHalt;
            end else begin
              done_c  = 1'b1;
              state_d = StFetch;
            end
          end
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        ALUOp   = alu_op_dec;
        ALUSrcA = alu_src_a_dec;
        ALUSrcB = alu_src_b_dec;
        ExtOp   = ext_op_dec;
        if (cls == ClsBranch) begin
          pc_write_c = Zero ^ is_bne;
          PCSrc      = 2'b01;
          done_c     = 1'b1;
          state_d    = StFetch;
        end else if (cls == ClsLoad || cls == ClsStore) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        // Address stays on the ALU for the whole access.
        ALUOp   = alu_op_dec;
        ALUSrcA = alu_src_a_dec;
        ALUSrcB = alu_src_b_dec;
        ExtOp   = ext_op_dec;
        if (cls == ClsStore) begin
          mem_write_c = 1'b1;
          if (DMemReady) begin
            done_c  = 1'b1;
            state_d = StFetch;
          end
        end else if (DMemReady) begin
          state_d = StWb;
        end
      end
      StWb: begin
        reg_write_c = 1'b1;
        WriteRegDst = (cls == ClsAluR) ? 2'b01 : 2'b00;
        ResultToReg = (cls == ClsLoad) ? 2'b01 : 2'b00;
        done_c      = 1'b1;
        state_d     = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Strobes are squashed while reset is low so a discarded instruction leaks nothing.
  assign IRWrite      = ir_write_c  & reset;
  assign PCWrite      = pc_write_c  & reset;
  assign MemWrite     = mem_write_c & reset;
  assign RegWrite     = reg_write_c & reset;
  assign InstrDone    = done_c      & reset;
  assign State        = state_q;
  assign IllegalInstr = illegal_q;
  assign InstrCount   = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StHalt) illegal_q <= 1'b1;
      if (done_c) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a trapping and a non-trapping instance share stimulus; an
// instruction-level reference model checks every cycle, plus directed latency vectors.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       ir_w;
    logic       pc_w;
    logic [1:0] pc_src;
    logic       mem_w;
    logic       reg_w;
    logic [1:0] res;
    logic [1:0] dst;
    logic [2:0] alu;
    logic       sa;
    logic       sb;
    logic [1:0] ext;
    logic [2:0] st;
    logic       done;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic       rtype;
    logic [3:0] kind;
    logic [2:0] alu;
    logic       sa;
    logic       sb;
    logic [1:0] ext;
  } ins_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         lat;
    logic [8:0] last;  // {RegWrite, WriteRegDst, ResultToReg, PCWrite, PCSrc, MemWrite}
  } vec_t;

  localparam logic [3:0] KAlu = 4'd0, KLw = 4'd1, KSw = 4'd2, KBeq = 4'd3, KBne = 4'd4;
  localparam logic [3:0] KJ = 4'd5, KJal = 4'd6, KJr = 4'd7, KIll = 4'd8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] Op = '0, Func = '0;
  logic       Zero = 1'b0, IMemReady = 1'b0, DMemReady = 1'b0;

  logic       ir_write [2];
  logic       pc_write [2];
  logic [1:0] pc_src [2];
  logic       mem_write [2];
  logic       reg_write [2];
  logic [1:0] res_to_reg [2];
  logic [1:0] wr_dst [2];
  logic [2:0] alu_op [2];
  logic       alu_src_a [2];
  logic       alu_src_b [2];
  logic [1:0] ext_op [2];
  logic [2:0] state [2];
  logic       instr_done [2];
  logic       illegal [2];
  logic [3:0] cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_ctrl #(
      .ILLEGAL_TRAP(g == 0 ? 1'b1 : 1'b0),
      .CNT_W       (4)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .Op          (Op),
      .Func        (Func),
      .Zero        (Zero),
      .IMemReady   (IMemReady),
      .DMemReady   (DMemReady),
      .IRWrite     (ir_write[g]),
      .PCWrite     (pc_write[g]),
      .PCSrc       (pc_src[g]),
      .MemWrite    (mem_write[g]),
      .RegWrite    (reg_write[g]),
      .ResultToReg (res_to_reg[g]),
      .WriteRegDst (wr_dst[g]),
      .ALUOp       (alu_op[g]),
      .ALUSrcA     (alu_src_a[g]),
      .ALUSrcB     (alu_src_b[g]),
      .ExtOp       (ext_op[g]),
      .State       (state[g]),
      .InstrDone   (instr_done[g]),
      .IllegalInstr(illegal[g]),
      .InstrCount  (cnt[g])
    );
  end

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  ins_t ins [20];
  vec_t vec [22];
  int   m_st [2];
  logic [3:0] m_cnt [2];
  logic m_ill [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic out_t dut_vec(input int g);
    out_t o;
    o.ir_w = ir_write[g];   o.pc_w = pc_write[g];   o.pc_src = pc_src[g];
    o.mem_w = mem_write[g]; o.reg_w = reg_write[g]; o.res = res_to_reg[g];
    o.dst = wr_dst[g];      o.alu = alu_op[g];      o.sa = alu_src_a[g];
    o.sb = alu_src_b[g];    o.ext = ext_op[g];      o.st = state[g];
    o.done = instr_done[g]; o.ill = illegal[g];
    return o;
  endfunction

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < 20; i++)
      if (ins[i].op == op && (!ins[i].rtype || ins[i].func == fn)) return i;
    return -1;
  endfunction

  // Instruction-level model: state numbers are the debug encoding, controls come from the table.
  task automatic model_eval(input int g, output out_t e, output int nst);
    int         idx;
    logic [3:0] k;
    ins_t       d;
    idx = find(Op, Func);
    k   = (idx < 0) ? KIll : ins[idx].kind;
    d   = (idx < 0) ? '0 : ins[idx];
    e   = '0;
    e.st  = 3'(m_st[g]);
    e.ill = m_ill[g];
    nst   = m_st[g];
    case (m_st[g])
      0: if (IMemReady) begin e.ir_w = 1; e.pc_w = 1; nst = 1; end
      1: begin
        case (k)
          KJ:   begin e.pc_w = 1; e.pc_src = 2; e.done = 1; nst = 0; end
          KJal: begin
            e.pc_w = 1; e.pc_src = 2; e.reg_w = 1; e.dst = 2; e.res = 2; e.done = 1; nst = 0;
          end
          KJr:  begin e.pc_w = 1; e.pc_src = 3; e.done = 1; nst = 0; end
          KIll: begin
            if (g == 0) nst = 5;
            else begin e.done = 1; nst = 0; end
          end
          default: nst = 2;
        endcase
      end
      2: begin
        e.alu = d.alu; e.sa = d.sa; e.sb = d.sb; e.ext = d.ext;
        if (k == KBeq || k == KBne) begin
          e.pc_w = Zero ^ (k == KBne); e.pc_src = 1; e.done = 1; nst = 0;
        end else if (k == KLw || k == KSw) nst = 3;
        else nst = 4;
      end
      3: begin
        e.alu = d.alu; e.sa = d.sa; e.sb = d.sb; e.ext = d.ext;
        if (k == KSw) begin
          e.mem_w = 1;
          if (DMemReady) begin e.done = 1; nst = 0; end
        end else if (DMemReady) nst = 4;
      end
      4: begin
        e.reg_w = 1; e.dst = d.rtype ? 2'b01 : 2'b00; e.res = (k == KLw) ? 2'b01 : 2'b00;
        e.done = 1; nst = 0;
      end
      default: ;
    endcase
    if (!reset) begin
      e.ir_w = 0; e.pc_w = 0; e.mem_w = 0; e.reg_w = 0; e.done = 0; nst = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 2; g++) begin
        out_t e;
        int   nst;
        model_eval(g, e, nst);
        check($sformatf("outputs[dut%0d]", g), 32'(dut_vec(g)), 32'(e));
        check($sformatf("count[dut%0d]", g), 32'(cnt[g]), 32'(m_cnt[g]));
        if (!reset) begin
          m_cnt[g] = '0; m_ill[g] = 1'b0;
        end else begin
          if (e.done) m_cnt[g] = m_cnt[g] + 4'd1;
          if (nst == 5) m_ill[g] = 1'b1;
        end
        m_st[g] = nst;
      end
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic r, input logic im, input logic dm, input logic z);
    @(posedge clk);
    #1;
    Op = op; Func = fn; reset = r; IMemReady = im; DMemReady = dm; Zero = z;
  endtask

  task automatic run_one(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         output int lat, output out_t last);
    lat  = -1;
    last = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      drive(op, fn, 1, 1, 1, z);
      #2;
      if (instr_done[0]) begin lat = c; last = dut_vec(0); end
    end
  endtask

  initial begin
    int         lat;
    out_t       o;
    logic [20:0] seq;
    logic       strb;

    ins[0]  = '{6'h00, 6'h20, 1, KAlu, 3'b000, 0, 0, 2'b00};
    ins[1]  = '{6'h00, 6'h21, 1, KAlu, 3'b000, 0, 0, 2'b00};
    ins[2]  = '{6'h00, 6'h22, 1, KAlu, 3'b001, 0, 0, 2'b00};
    ins[3]  = '{6'h00, 6'h23, 1, KAlu, 3'b001, 0, 0, 2'b00};
    ins[4]  = '{6'h00, 6'h24, 1, KAlu, 3'b011, 0, 0, 2'b00};
    ins[5]  = '{6'h00, 6'h25, 1, KAlu, 3'b010, 0, 0, 2'b00};
    ins[6]  = '{6'h00, 6'h26, 1, KAlu, 3'b100, 0, 0, 2'b00};
    ins[7]  = '{6'h00, 6'h00, 1, KAlu, 3'b101, 1, 0, 2'b11};
    ins[8]  = '{6'h00, 6'h02, 1, KAlu, 3'b110, 1, 0, 2'b11};
    ins[9]  = '{6'h00, 6'h08, 1, KJr,  3'b000, 0, 0, 2'b00};
    ins[10] = '{6'h08, 6'h00, 0, KAlu, 3'b000, 0, 1, 2'b00};
    ins[11] = '{6'h09, 6'h00, 0, KAlu, 3'b000, 0, 1, 2'b00};
    ins[12] = '{6'h0D, 6'h00, 0, KAlu, 3'b010, 0, 1, 2'b01};
    ins[13] = '{6'h0F, 6'h00, 0, KAlu, 3'b000, 0, 1, 2'b10};
    ins[14] = '{6'h23, 6'h00, 0, KLw,  3'b000, 0, 1, 2'b00};
    ins[15] = '{6'h2B, 6'h00, 0, KSw,  3'b000, 0, 1, 2'b00};
    ins[16] = '{6'h04, 6'h00, 0, KBeq, 3'b001, 0, 0, 2'b00};
    ins[17] = '{6'h05, 6'h00, 0, KBne, 3'b001, 0, 0, 2'b00};
    ins[18] = '{6'h02, 6'h00, 0, KJ,   3'b000, 0, 0, 2'b00};
    ins[19] = '{6'h03, 6'h00, 0, KJal, 3'b000, 0, 0, 2'b00};

    vec[0]  = '{"addu",    6'h00, 6'h21, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[1]  = '{"add",     6'h00, 6'h20, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[2]  = '{"sub",     6'h00, 6'h22, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[3]  = '{"subu",    6'h00, 6'h23, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[4]  = '{"and",     6'h00, 6'h24, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[5]  = '{"or",      6'h00, 6'h25, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[6]  = '{"xor",     6'h00, 6'h26, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[7]  = '{"sll",     6'h00, 6'h00, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[8]  = '{"srl",     6'h00, 6'h02, 1'b0, 4, 9'b1_01_00_0_00_0};
    vec[9]  = '{"addi",    6'h08, 6'h00, 1'b0, 4, 9'b1_00_00_0_00_0};
    vec[10] = '{"addiu",   6'h09, 6'h00, 1'b0, 4, 9'b1_00_00_0_00_0};
    vec[11] = '{"ori",     6'h0D, 6'h00, 1'b0, 4, 9'b1_00_00_0_00_0};
    vec[12] = '{"lui",     6'h0F, 6'h00, 1'b0, 4, 9'b1_00_00_0_00_0};
    vec[13] = '{"lw",      6'h23, 6'h00, 1'b0, 5, 9'b1_00_01_0_00_0};
    vec[14] = '{"sw",      6'h2B, 6'h00, 1'b0, 4, 9'b0_00_00_0_00_1};
    vec[15] = '{"beq_z1",  6'h04, 6'h00, 1'b1, 3, 9'b0_00_00_1_01_0};
    vec[16] = '{"beq_z0",  6'h04, 6'h00, 1'b0, 3, 9'b0_00_00_0_01_0};
    vec[17] = '{"bne_z1",  6'h05, 6'h00, 1'b1, 3, 9'b0_00_00_0_01_0};
    vec[18] = '{"bne_z0",  6'h05, 6'h00, 1'b0, 3, 9'b0_00_00_1_01_0};
    vec[19] = '{"j",       6'h02, 6'h00, 1'b0, 2, 9'b0_00_00_1_10_0};
    vec[20] = '{"jal",     6'h03, 6'h00, 1'b0, 2, 9'b1_10_10_1_10_0};
    vec[21] = '{"jr",      6'h00, 6'h08, 1'b0, 2, 9'b0_00_00_1_11_0};

    for (int g = 0; g < 2; g++) begin m_st[g] = 0; m_cnt[g] = '0; m_ill[g] = 1'b0; end

    // Reset with IMemReady high: nothing may strobe.
    @(posedge clk);
    chk_en = 1'b1;
    drive(6'h00, 6'h21, 0, 1, 1, 0);
    #2;
    check("reset_state", {27'(state[0]), ir_write[0], pc_write[0], illegal[0], cnt[0][0]},
          32'h0);
    check("reset_count", 32'(cnt[0]), 32'h0);

    for (int i = 0; i < 22; i++) begin
      run_one(vec[i].op, vec[i].func, vec[i].zero, lat, o);
      check({vec[i].name, "_latency"}, 32'(lat), 32'(vec[i].lat));
      check({vec[i].name, "_retire"}, 32'({o.reg_w, o.dst, o.res, o.pc_w, o.pc_src, o.mem_w}),
            32'(vec[i].last));
    end
    drive(6'h00, 6'h21, 1, 0, 0, 0);
    #2;
    check("count_after_table", 32'(cnt[0]), 32'(22 % 16));

    // lw with a two-cycle data stall.
    seq = '0; strb = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      drive(6'h23, 6'h00, 1, 1, (c >= 6), 0);
      #2;
      seq = {seq[17:0], state[0]};
      if (c >= 4 && c <= 6)
        strb |= ir_write[0] | pc_write[0] | mem_write[0] | reg_write[0] | instr_done[0];
      if (c == 7)
        check("lw_stall_wb", 32'({reg_write[0], res_to_reg[0], wr_dst[0], instr_done[0]}),
              32'b1_01_00_1);
    end
    check("lw_stall_states", 32'(seq), 32'(21'b000_001_010_011_011_011_100));
    check("lw_stall_mem_quiet", 32'(strb), 32'h0);

    // sw interrupted by reset while waiting in MEM.
    drive(6'h2B, 6'h00, 1, 1, 0, 0);
    drive(6'h2B, 6'h00, 1, 1, 0, 0);
    drive(6'h2B, 6'h00, 1, 1, 0, 0);
    drive(6'h2B, 6'h00, 1, 1, 0, 0);
    #2;
    check("sw_wait_memwrite", 32'(mem_write[0]), 32'h1);
    drive(6'h2B, 6'h00, 0, 1, 0, 0);
    #2;
    check("sw_reset_strobes", 32'({mem_write[0], instr_done[0]}), 32'h0);
    drive(6'h2B, 6'h00, 1, 0, 0, 0);
    #2;
    check("sw_reset_after", 32'({state[0], cnt[0]}), 32'h0);

    // Counter wrap at CNT_W=4.
    for (int i = 0; i < 15; i++) run_one(6'h02, 6'h00, 0, lat, o);
    drive(6'h02, 6'h00, 1, 0, 0, 0);
    #2;
    check("count_at_max", 32'(cnt[0]), 32'd15);
    run_one(6'h02, 6'h00, 0, lat, o);
    drive(6'h02, 6'h00, 1, 0, 0, 0);
    #2;
    check("count_wrapped", 32'(cnt[0]), 32'd0);

    // Illegal opcode: trap instance halts, the other retires it as a NOP.
    run_one(6'h02, 6'h00, 0, lat, o);
    drive(6'h3F, 6'h3F, 1, 1, 1, 0);
    drive(6'h3F, 6'h3F, 1, 1, 1, 0);
    #2;
    check("illegal_decode_done", 32'({instr_done[1], instr_done[0]}), 32'b10);
    for (int i = 0; i < 3; i++) drive(6'h3F, 6'h3F, 1, 1, 1, 0);
    #2;
    check("illegal_halt", 32'({state[0], illegal[0], cnt[0]}), 32'({3'b101, 1'b1, 4'd1}));
    check("illegal_nop_flag", 32'(illegal[1]), 32'h0);
    drive(6'h3F, 6'h3F, 0, 1, 1, 0);
    drive(6'h00, 6'h21, 1, 0, 0, 0);
    #2;
    check("halt_reset", 32'({state[0], illegal[0], cnt[0]}), 32'h0);

    // Random traffic; a new instruction only appears when both instances are idle.
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] op_n, fn_n;
      @(posedge clk);
      #1;
      op_n = Op; fn_n = Func;
      if ((m_st[0] == 0 || m_st[0] == 5) && (m_st[1] == 0 || m_st[1] == 5) &&
          $urandom_range(0, 2) == 0) begin
        int k;
        if ($urandom_range(0, 9) == 0) begin
          op_n = 6'($urandom); fn_n = 6'($urandom);
        end else begin
          k    = $urandom_range(0, 19);
          op_n = ins[k].op;
          fn_n = ins[k].rtype ? ins[k].func : 6'($urandom);
        end
      end
      Op = op_n; Func = fn_n;
      reset     = ($urandom_range(0, 49) != 0);
      IMemReady = ($urandom_range(0, 3) != 0);
      DMemReady = ($urandom_range(0, 4) < 3);
      Zero      = 1'($urandom);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
